if_fetch_unit: RTL

- Instruction-fetch stage of the 5-stage pipeline and the writer side of the IF/ID pipeline register.
- Holds the PC and drives the synchronous-read instruction memory.
- Delivers `instruction_out` and `pc_incrementado_out` to the IF/ID latch every cycle. That latch has no enable, so this block handles stall (replay), flush (NOP injection), branch/jump redirect and halt.

---
 rtl/if_fetch_unit_if.sv | 32 +++
 rtl/if_fetch_unit.sv | 90 +++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch unit and its surroundings: hazard/redirect
// controls, the instruction-memory port and the IF/ID latch outputs.
interface if_fetch_unit_if #(
  parameter int B      = 32,
  parameter int ADDR_W = 7
);
  logic              stall;
  logic              flush;
  logic              pc_src;
  logic [B-1:0]      branch_target;
  logic              jump;
  logic [B-1:0]      jump_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [B-1:0]      imem_data;
  logic [B-1:0]      instruction_out;
  logic [B-1:0]      pc_incrementado_out;
  logic              valid_out;
  logic              halted;
  logic [B-1:0]      pc_out;

  // Fetch unit side.
  modport master (
    input  stall, flush, pc_src, branch_target, jump, jump_target, imem_data,
    output imem_addr, instruction_out, pc_incrementado_out, valid_out, halted, pc_out
  );

  // Environment side: hazard unit, ID stage, instruction memory, IF/ID latch.
  modport slave (
    output stall, flush, pc_src, branch_target, jump, jump_target, imem_data,
    input  imem_addr, instruction_out, pc_incrementado_out, valid_out, halted, pc_out
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a synchronous-read
// instruction memory and feeds the enable-less IF/ID latch, handling
// stall replay, flush NOP injection, branch/jump redirect and halt.
module if_fetch_unit #(
  parameter int         B           = 32,
  parameter int         ADDR_W      = 7,
  parameter logic [5:0] HALT_OPCODE = 6'b111111,
  parameter logic [B-1:0] NOP       = '0
) (
  input logic            clk,
  input logic            reset,
  if_fetch_unit_if.master bus
);

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [B-1:0] pc_q, pc_d;
  logic [B-1:0] pc_plus1;
  logic         halt_hit;

  assign pc_plus1 = pc_q + 1'b1;

  // The word on imem_data belongs to pc_q; a halt only counts when that
  // word is really being delivered (not flushed, not replayed).
  assign halt_hit = (state_q == S_RUN) && (bus.imem_data[31:26] == HALT_OPCODE)
                    && !bus.flush && !bus.stall;

  // Next PC and next state selection.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred; blocking '=' is the
    // right assignment inside combinational logic.
    pc_d    = pc_q;
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        pc_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.stall)         pc_d = pc_q;
        else if (halt_hit)     pc_d = pc_plus1;
        else if (bus.jump)     pc_d = bus.jump_target;
        else if (bus.pc_src)   pc_d = bus.branch_target;
        else                   pc_d = pc_plus1;
        if (halt_hit) state_d = S_HALT;
      end
      S_HALT: begin
        pc_d = pc_q;
      end
      default: begin
        pc_d    = '0;
        state_d = S_FILL;
      end
    endcase
    if (reset) begin
      pc_d    = '0;
      state_d = S_FILL;
    end
  end

  // PC and state registers with synchronous reset folded into pc_d/state_d.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples its inputs from the same edge, independent of statement order.
    pc_q    <= pc_d;
    state_q <= state_d;
  end

  // IF/ID outputs depend only on registered state plus flush/imem_data.
  always_comb begin
    bus.instruction_out = NOP;
    bus.valid_out       = 1'b0;
    bus.halted          = 1'b0;
    if (state_q == S_RUN) begin
      bus.instruction_out = bus.flush ? NOP : bus.imem_data;
      bus.valid_out       = !bus.flush;
    end else if (state_q == S_HALT) begin
      bus.halted = 1'b1;
    end
  end

  assign bus.imem_addr           = pc_d[ADDR_W-1:0];
  assign bus.pc_incrementado_out = pc_plus1;
  assign bus.pc_out              = pc_q;

endmodule
